// File: rtl/dcpu16_fsctl_if.sv
// dcpu16_fsctl_if - simplified-Wishbone FS (fetch/store) memory bus.
//
// Signals:
//   fs_adr  16  bus address                (controller -> memory)
//   fs_stb   1  bus strobe                 (controller -> memory)
//   fs_wre   1  write enable, 1 = store    (controller -> memory)
//   fs_dto  16  write data                 (controller -> memory)
//   fs_err   1  timeout pulse              (controller -> memory side observers)
//   fs_dti  16  read data                  (memory -> controller)
//   fs_ack   1  acknowledge                (memory -> controller)
//
// Modports: master = bus controller, slave = memory.
interface dcpu16_fsctl_if;
    logic [15:0] fs_adr;
    logic        fs_stb;
    logic        fs_wre;
    logic [15:0] fs_dto;
    logic        fs_err;
    logic [15:0] fs_dti;
    logic        fs_ack;

    modport master (
        output fs_adr, fs_stb, fs_wre, fs_dto, fs_err,
        input  fs_dti, fs_ack
    );

    modport slave (
        input  fs_adr, fs_stb, fs_wre, fs_dto, fs_err,
        output fs_dti, fs_ack
    );
endinterface

// File: rtl/dcpu16_fsctl.sv
// dcpu16_fsctl - sequencer and round-robin arbiter for the FS memory bus.
//
// Shares one FS bus port between the instruction-fetch requester (fr_*)
// and the data-store requester (sr_*). All bus outputs are registered;
// requester acks, fr_dat and ena are combinational; pha is registered.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   fr_stb/fr_adr     fetch request and address
//   fr_ack/fr_dat     fetch complete and read data
//   sr_stb/sr_adr/sr_dat  store request, address and data
//   sr_ack            store complete
//   bus               FS bus (dcpu16_fsctl_if.master)
//   ena               core advance enable
//   pha               core phase, toggles on every enabled edge
//
// Parameters:
//   TMO               bus-cycle timeout in cycles (1..255)
//
// Optional feature: define DCPU16_FS_TIMEOUT_EN to terminate bus cycles
// that see no fs_ack within TMO strobe cycles (pulses fs_err).
module dcpu16_fsctl #(
    parameter int unsigned TMO = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fr_stb,
    input  logic [15:0] fr_adr,
    output logic        fr_ack,
    output logic [15:0] fr_dat,
    input  logic        sr_stb,
    input  logic [15:0] sr_adr,
    input  logic [15:0] sr_dat,
    output logic        sr_ack,
    dcpu16_fsctl_if.master bus,
    output logic        ena,
    output logic        pha
);

    if (TMO < 1 || TMO > 255) begin : g_bad_tmo
        $error("dcpu16_fsctl: TMO must be in 1..255");
    end

    typedef enum logic [1:0] {IDLE, FETCH, STORE} state_t;

    state_t      state, state_n;
    logic [15:0] adr_q, adr_n;
    logic [15:0] dto_q, dto_n;
    logic        stb_q, stb_n;
    logic        wre_q, wre_n;
    logic        err_q, err_n;
    logic        last_store, last_store_n;
    logic        pha_q;
    logic        tmo_hit;
    logic        done;

`ifdef DCPU16_FS_TIMEOUT_EN
    logic [7:0] cnt;

    // cnt holds the number of unacked strobe cycles already elapsed, so the
    // TMO-th strobe cycle is the one where cnt == TMO-1.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            cnt <= '0;
        end else if (stb_q && !bus.fs_ack) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tmo_hit = (state != IDLE) && !bus.fs_ack && (cnt == 8'(TMO - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // A same-cycle fs_ack wins over the timeout (tmo_hit excludes it).
    assign done   = (state != IDLE) && (bus.fs_ack || tmo_hit);
    assign fr_ack = !rst && (state == FETCH) && done;
    assign sr_ack = !rst && (state == STORE) && done;
    assign fr_dat = tmo_hit ? '0 : bus.fs_dti;
    assign ena    = !((fr_stb && !fr_ack) || (sr_stb && !sr_ack));

    always_comb begin
        state_n      = state;
        adr_n        = adr_q;
        dto_n        = dto_q;
        stb_n        = stb_q;
        wre_n        = wre_q;
        err_n        = 1'b0;
        last_store_n = last_store;
        case (state)
            IDLE: begin
                // Fetch wins unless a store is also pending and fetch went last.
                if (fr_stb && (!sr_stb || last_store)) begin
                    state_n      = FETCH;
                    adr_n        = fr_adr;
                    wre_n        = 1'b0;
                    stb_n        = 1'b1;
                    last_store_n = 1'b0;
                end else if (sr_stb) begin
                    state_n      = STORE;
                    adr_n        = sr_adr;
                    dto_n        = sr_dat;
                    wre_n        = 1'b1;
                    stb_n        = 1'b1;
                    last_store_n = 1'b1;
                end
            end
            FETCH, STORE: begin
                if (done) begin
                    state_n = IDLE;
                    stb_n   = 1'b0;
                    wre_n   = 1'b0;
                    err_n   = tmo_hit;
                end
            end
            default: begin
                state_n = IDLE;
                stb_n   = 1'b0;
                wre_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            adr_q      <= '0;
            dto_q      <= '0;
            stb_q      <= 1'b0;
            wre_q      <= 1'b0;
            err_q      <= 1'b0;
            last_store <= 1'b1;
            pha_q      <= 1'b0;
        end else begin
            state      <= state_n;
            adr_q      <= adr_n;
            dto_q      <= dto_n;
            stb_q      <= stb_n;
            wre_q      <= wre_n;
            err_q      <= err_n;
            last_store <= last_store_n;
            pha_q      <= pha_q ^ ena;
        end
    end

    assign bus.fs_adr = adr_q;
    assign bus.fs_dto = dto_q;
    assign bus.fs_stb = stb_q;
    assign bus.fs_wre = wre_q;
    assign bus.fs_err = err_q;
    assign pha        = pha_q;

endmodule

// File: tb/tb_dcpu16_fsctl.sv
// tb_dcpu16_fsctl - self-checking bench for dcpu16_fsctl.
// Expected bus transfers are queued when requests are raised and popped
// when the bus acknowledges them.
module tb_dcpu16_fsctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fr_stb;
    logic [15:0] fr_adr;
    logic        fr_ack;
    logic [15:0] fr_dat;
    logic        sr_stb;
    logic [15:0] sr_adr;
    logic [15:0] sr_dat;
    logic        sr_ack;
    logic        ena;
    logic        pha;

    dcpu16_fsctl_if bus ();

    dcpu16_fsctl #(.TMO(15)) dut (
        .clk    (clk),
        .rst    (rst),
        .fr_stb (fr_stb),
        .fr_adr (fr_adr),
        .fr_ack (fr_ack),
        .fr_dat (fr_dat),
        .sr_stb (sr_stb),
        .sr_adr (sr_adr),
        .sr_dat (sr_dat),
        .sr_ack (sr_ack),
        .bus    (bus.master),
        .ena    (ena),
        .pha    (pha)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wre;
        logic [15:0] adr;
        logic [15:0] dat;
    } xfer_t;

    xfer_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic test_reset();
        rst = 1'b1;
        fr_stb = 1'b0; fr_adr = '0;
        sr_stb = 1'b0; sr_adr = '0; sr_dat = '0;
        bus.fs_ack = 1'b0; bus.fs_dti = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.fs_stb !== 1'b0 || bus.fs_wre !== 1'b0 || bus.fs_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: stb/wre/err=%b%b%b required 000", bus.fs_stb, bus.fs_wre, bus.fs_err);
        end
        n_checks++;
        if (bus.fs_adr !== 16'h0000 || bus.fs_dto !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_data: adr=%h dto=%h required 0000 0000", bus.fs_adr, bus.fs_dto);
        end
        n_checks++;
        if (pha !== 1'b0 || ena !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pha: pha=%b ena=%b required 0 1", pha, ena);
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (pha !== 1'(i % 2) || bus.fs_stb !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_pha[%0d]: pha=%b stb=%b required %b 0", i, pha, bus.fs_stb, 1'(i % 2));
            end
        end
    endtask

    // Three phases: tie (fetch first), solo fetch, tie (store first).
    task automatic test_round_robin();
        xfer_t e;
        int    nexp, got, a1;
        logic  drop_f, drop_s;
        for (int ph = 0; ph < 3; ph++) begin
            @(negedge clk);
            fr_stb = 1'b0; sr_stb = 1'b0; bus.fs_ack = 1'b0;
            @(negedge clk);
            fr_stb = 1'b1; fr_adr = 16'h0200 + 16'(ph);
            bus.fs_dti = 16'hA000 + 16'(ph);
            sr_stb = (ph != 1); sr_adr = 16'h8000; sr_dat = 16'hBEEF;
            if (ph == 0) begin
                exp_q.push_back({1'b0, fr_adr, bus.fs_dti});
                exp_q.push_back({1'b1, sr_adr, sr_dat});
            end else if (ph == 1) begin
                exp_q.push_back({1'b0, fr_adr, bus.fs_dti});
            end else begin
                exp_q.push_back({1'b1, sr_adr, sr_dat});
                exp_q.push_back({1'b0, fr_adr, bus.fs_dti});
            end
            nexp = (ph == 1) ? 1 : 2;
            #1;
            n_checks++;
            if (ena !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_ena_req[%0d]: ena=%b required 0", ph, ena);
            end
            got = 0; a1 = 0; drop_f = 1'b0; drop_s = 1'b0;
            for (int cyc = 1; cyc <= 20 && got < nexp; cyc++) begin
                @(negedge clk);
                if (drop_f) fr_stb = 1'b0;
                if (drop_s) sr_stb = 1'b0;
                drop_f = 1'b0; drop_s = 1'b0;
                bus.fs_ack = bus.fs_stb;
                #1;
                if (bus.fs_stb === 1'b1 && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    got++;
                    n_checks++;
                    if (bus.fs_wre !== e.wre || bus.fs_adr !== e.adr) begin
                        n_fail++;
                        $display("FAIL rr_bus[%0d.%0d]: wre=%b adr=%h required %b %h", ph, got, bus.fs_wre, bus.fs_adr, e.wre, e.adr);
                    end
                    n_checks++;
                    if (e.wre) begin
                        if (sr_ack !== 1'b1 || fr_ack !== 1'b0 || bus.fs_dto !== e.dat) begin
                            n_fail++;
                            $display("FAIL rr_store[%0d.%0d]: sr_ack=%b fr_ack=%b dto=%h required 1 0 %h", ph, got, sr_ack, fr_ack, bus.fs_dto, e.dat);
                        end
                        drop_s = 1'b1;
                    end else begin
                        if (fr_ack !== 1'b1 || sr_ack !== 1'b0 || fr_dat !== e.dat) begin
                            n_fail++;
                            $display("FAIL rr_fetch[%0d.%0d]: fr_ack=%b sr_ack=%b dat=%h required 1 0 %h", ph, got, fr_ack, sr_ack, fr_dat, e.dat);
                        end
                        drop_f = 1'b1;
                    end
                    n_checks++;
                    if (got == 1) begin
                        a1 = cyc;
                        if (cyc != 1) begin
                            n_fail++;
                            $display("FAIL rr_latency[%0d]: first strobe cycle=%0d required 1", ph, cyc);
                        end
                    end else if (cyc - a1 != 2) begin
                        n_fail++;
                        $display("FAIL rr_gap[%0d]: ack spacing=%0d required 2", ph, cyc - a1);
                    end
                end
            end
            n_checks++;
            if (got != nexp) begin
                n_fail++;
                $display("FAIL rr_timeout[%0d]: transfers=%0d required %0d", ph, got, nexp);
                exp_q.delete();
            end
        end
        @(negedge clk);
        fr_stb = 1'b0; sr_stb = 1'b0; bus.fs_ack = 1'b0;
    endtask

    task automatic test_fetch_wait();
        xfer_t e;
        logic  frozen;
        @(negedge clk);
        fr_stb = 1'b1; fr_adr = 16'h0100; bus.fs_dti = 16'h7C01; bus.fs_ack = 1'b0;
        exp_q.push_back({1'b0, 16'h0100, 16'h7C01});
        #1;
        frozen = pha;
        n_checks++;
        if (ena !== 1'b0) begin
            n_fail++;
            $display("FAIL fw_ena_req: ena=%b required 0", ena);
        end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 4) bus.fs_ack = 1'b1;
            #1;
            n_checks++;
            if (bus.fs_stb !== 1'b1 || bus.fs_adr !== 16'h0100 || bus.fs_wre !== 1'b0 || pha !== frozen) begin
                n_fail++;
                $display("FAIL fw_hold[%0d]: stb=%b adr=%h wre=%b pha=%b required 1 0100 0 %b", i, bus.fs_stb, bus.fs_adr, bus.fs_wre, pha, frozen);
            end
            n_checks++;
            if (i < 4) begin
                if (fr_ack !== 1'b0 || ena !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fw_wait[%0d]: fr_ack=%b ena=%b required 0 0", i, fr_ack, ena);
                end
            end else begin
                e = exp_q.pop_front();
                if (fr_ack !== 1'b1 || fr_dat !== e.dat || ena !== 1'b1 || bus.fs_adr !== e.adr) begin
                    n_fail++;
                    $display("FAIL fw_ack: fr_ack=%b dat=%h ena=%b required 1 %h 1", fr_ack, fr_dat, ena, e.dat);
                end
            end
        end
        @(negedge clk);
        fr_stb = 1'b0; bus.fs_ack = 1'b0;
        #1;
        n_checks++;
        if (bus.fs_stb !== 1'b0 || pha !== ~frozen) begin
            n_fail++;
            $display("FAIL fw_done: stb=%b pha=%b required 0 %b", bus.fs_stb, pha, ~frozen);
        end
    endtask

    task automatic test_reset_mid_store();
        @(negedge clk);
        sr_stb = 1'b1; sr_adr = 16'h4000; sr_dat = 16'h55AA;
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.fs_stb !== 1'b1 || bus.fs_wre !== 1'b1 || bus.fs_dto !== 16'h55AA) begin
            n_fail++;
            $display("FAIL rs_start: stb=%b wre=%b dto=%h required 1 1 55AA", bus.fs_stb, bus.fs_wre, bus.fs_dto);
        end
        @(negedge clk);
        rst = 1'b1; bus.fs_ack = 1'b1;
        #1;
        n_checks++;
        if (sr_ack !== 1'b0 || fr_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rs_noack: sr_ack=%b fr_ack=%b required 0 0", sr_ack, fr_ack);
        end
        @(negedge clk);
        rst = 1'b0; sr_stb = 1'b0; bus.fs_ack = 1'b0;
        #1;
        n_checks++;
        if (bus.fs_stb !== 1'b0 || bus.fs_wre !== 1'b0 || pha !== 1'b0 || bus.fs_adr !== 16'h0000) begin
            n_fail++;
            $display("FAIL rs_drop: stb=%b wre=%b pha=%b adr=%h required 0 0 0 0000", bus.fs_stb, bus.fs_wre, pha, bus.fs_adr);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.fs_stb !== 1'b0 || sr_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rs_idle: stb=%b sr_ack=%b required 0 0", bus.fs_stb, sr_ack);
        end
    endtask

    task automatic test_stray_ack();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            fr_stb = 1'b0; sr_stb = 1'b0; bus.fs_ack = (i < 2);
            #1;
            n_checks++;
            if (fr_ack !== 1'b0 || sr_ack !== 1'b0 || ena !== 1'b1 || bus.fs_stb !== 1'b0 || bus.fs_err !== 1'b0) begin
                n_fail++;
                $display("FAIL stray_ack[%0d]: fr_ack=%b sr_ack=%b ena=%b stb=%b err=%b required 0 0 1 0 0", i, fr_ack, sr_ack, ena, bus.fs_stb, bus.fs_err);
            end
        end
    endtask

`ifdef DCPU16_FS_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge clk);
        fr_stb = 1'b1; fr_adr = 16'h0300; bus.fs_dti = 16'hFFFF; bus.fs_ack = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (bus.fs_stb !== 1'b1 || fr_ack !== (i == 15)) begin
                n_fail++;
                $display("FAIL tmo_wait[%0d]: stb=%b fr_ack=%b required 1 %b", i, bus.fs_stb, fr_ack, (i == 15));
            end
        end
        n_checks++;
        if (fr_dat !== 16'h0000) begin
            n_fail++;
            $display("FAIL tmo_dat: fr_dat=%h required 0000", fr_dat);
        end
        @(negedge clk);
        fr_stb = 1'b0;
        #1;
        n_checks++;
        if (bus.fs_stb !== 1'b0 || bus.fs_err !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_err: stb=%b err=%b required 0 1", bus.fs_stb, bus.fs_err);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.fs_err !== 1'b0 || bus.fs_stb !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_err_end: err=%b stb=%b required 0 0", bus.fs_err, bus.fs_stb);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_fetch_wait();
        test_reset_mid_store();
        test_stray_ack();
`ifdef DCPU16_FS_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
